// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 receive monitor: FSM encoding and default geometry.
package hub75_pkg;

    localparam logic [0:0] ST_SHIFT = 1'b0;
    localparam logic [0:0] ST_LATCH = 1'b1;

    localparam int unsigned DEF_N_ROWS = 32;
    localparam int unsigned DEF_N_COLS = 64;
    localparam int unsigned LOG_N_ROWS = $clog2(DEF_N_ROWS);
    localparam int unsigned LOG_N_COLS = $clog2(DEF_N_COLS);

endpackage

// File: rtl/hub75_rx_if.sv
// HUB75 pad bundle; the driver side is master, the receive monitor is slave.
interface hub75_rx_if #(
    parameter int unsigned N_BANKS = 2,
    parameter int unsigned N_ROWS  = 32,
    parameter int unsigned N_CHANS = 3
) ();

    logic [$clog2(N_ROWS)-1:0]  hub75_addr;
    logic [N_BANKS*N_CHANS-1:0] hub75_data;
    logic                       hub75_clk;
    logic                       hub75_le;
    logic                       hub75_blank;

    modport master (
        output hub75_addr, hub75_data, hub75_clk, hub75_le, hub75_blank
    );

    modport slave (
        input hub75_addr, hub75_data, hub75_clk, hub75_le, hub75_blank
    );

endinterface

// File: rtl/hub75_rx_sync.sv
// 2-flop synchroniser plus history stage; q and the registered rise/fall
// strobes are mutually aligned, so data bits line up with their clock edge.
module hub75_rx_sync #(
    parameter int unsigned    W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] s1_q, s1_d;
    logic [W-1:0] s2_q, s2_d;
    logic [W-1:0] hist_q, hist_d;
    logic [W-1:0] rise_q, rise_d;
    logic [W-1:0] fall_q, fall_d;

    always_comb begin
        s1_d   = d;
        s2_d   = s1_q;
        hist_d = s2_q;
        rise_d = s2_q & ~hist_q;
        fall_d = ~s2_q & hist_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= RST_VAL;
            s2_q   <= RST_VAL;
            hist_q <= RST_VAL;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            hist_q <= hist_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign q    = hist_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/hub75_rx.sv
// HUB75 receive monitor: rebuilds shifted columns into line-buffer writes and
// reports per-latch row, column count and blank-low time.
module hub75_rx
    import hub75_pkg::*;
#(
    parameter int unsigned N_BANKS = 2,
    parameter int unsigned N_ROWS  = 2 ** LOG_N_ROWS,
    parameter int unsigned N_COLS  = 2 ** LOG_N_COLS,
    parameter int unsigned N_CHANS = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    hub75_rx_if.slave                    hub75,
    output logic [$clog2(N_COLS)-1:0]    cap_col_addr,
    output logic [N_BANKS*N_CHANS-1:0]   cap_data,
    output logic                         cap_wren,
    output logic                         lat_valid,
    output logic [$clog2(N_ROWS)-1:0]    lat_row,
    output logic [$clog2(N_COLS):0]      lat_ncols,
    output logic                         lat_ok,
    output logic [CNT_W-1:0]             lat_on_len,
    output logic                         err_overrun,
    output logic                         err_clk_in_le,
    input  logic                         err_clr
);

    localparam int unsigned AW      = $clog2(N_ROWS);
    localparam int unsigned CW      = $clog2(N_COLS);
    localparam int unsigned DW      = N_BANKS * N_CHANS;
    localparam int unsigned B_CLK   = AW + DW;
    localparam int unsigned B_LE    = AW + DW + 1;
    localparam int unsigned B_BLANK = AW + DW + 2;
    localparam int unsigned PW      = AW + DW + 3;

    localparam logic [CW:0]   COL_FULL = (CW + 1)'(N_COLS);
    localparam logic [CW:0]   COL_SAT  = (CW + 1)'(N_COLS + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(N_COLS - 1);
    // blank resets high so the pipeline does not count phantom on-time after reset
    localparam logic [PW-1:0] PAD_RST  = {1'b1, {(PW - 1){1'b0}}};

    logic [PW-1:0] pad_raw, pad_q, pad_rise, pad_fall;

    assign pad_raw = {hub75.hub75_blank, hub75.hub75_le, hub75.hub75_clk,
                      hub75.hub75_data, hub75.hub75_addr};

    hub75_rx_sync #(
        .W       (PW),
        .RST_VAL (PAD_RST)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (pad_raw),
        .q    (pad_q),
        .rise (pad_rise),
        .fall (pad_fall)
    );

    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_data;
    logic          sclk_rise, le_rise, le_fall, blank_on;
    logic          unused_pads;

    assign s_addr    = pad_q[AW-1:0];
    assign s_data    = pad_q[AW +: DW];
    assign sclk_rise = pad_rise[B_CLK];
    assign le_rise   = pad_rise[B_LE];
    assign le_fall   = pad_fall[B_LE];
    assign blank_on  = ~pad_q[B_BLANK];
    assign unused_pads = ^{pad_q[B_LE:B_CLK], pad_rise[B_CLK-1:0], pad_rise[B_BLANK],
                           pad_fall[B_LE-1:0], pad_fall[B_BLANK]};

    logic [0:0]       state_q, state_d;
    logic [CW:0]      col_cnt_q, col_cnt_d;
    logic [CNT_W-1:0] on_cnt_q, on_cnt_d;
    logic             per_err_q, per_err_d;
    logic [CW-1:0]    cap_col_addr_q, cap_col_addr_d;
    logic [DW-1:0]    cap_data_q, cap_data_d;
    logic             cap_wren_q, cap_wren_d;
    logic             lat_valid_q, lat_valid_d;
    logic [AW-1:0]    lat_row_q, lat_row_d;
    logic [CW:0]      lat_ncols_q, lat_ncols_d;
    logic             lat_ok_q, lat_ok_d;
    logic [CNT_W-1:0] lat_on_len_q, lat_on_len_d;
    logic             err_overrun_q, err_overrun_d;
    logic             err_clk_in_le_q, err_clk_in_le_d;

    logic latch_now, set_ovr, set_cle;

    always_comb begin
        state_d        = state_q;
        col_cnt_d      = col_cnt_q;
        on_cnt_d       = on_cnt_q;
        per_err_d      = per_err_q;
        cap_col_addr_d = cap_col_addr_q;
        cap_data_d     = cap_data_q;
        cap_wren_d     = 1'b0;
        lat_valid_d    = 1'b0;
        lat_row_d      = lat_row_q;
        lat_ncols_d    = lat_ncols_q;
        lat_ok_d       = lat_ok_q;
        lat_on_len_d   = lat_on_len_q;
        set_ovr        = 1'b0;
        set_cle        = 1'b0;
        latch_now      = le_rise && (state_q == ST_SHIFT);

        if (blank_on && (on_cnt_q != '1)) begin
            on_cnt_d = on_cnt_q + CNT_W'(1);
        end

        if (latch_now) begin
            lat_valid_d  = 1'b1;
            lat_row_d    = s_addr;
            lat_ncols_d  = col_cnt_q;
            lat_ok_d     = (col_cnt_q == COL_FULL) && !per_err_q;
            lat_on_len_d = on_cnt_q;
            col_cnt_d    = '0;
            on_cnt_d     = blank_on ? CNT_W'(1) : '0;
            per_err_d    = 1'b0;
            state_d      = ST_LATCH;
        end else if (le_fall && (state_q == ST_LATCH)) begin
            state_d = ST_SHIFT;
        end

        // a shift edge coinciding with the latch belongs to the new latch period
        if (sclk_rise) begin
            if (latch_now || (state_q == ST_LATCH)) begin
                set_cle   = 1'b1;
                per_err_d = 1'b1;
            end else if (col_cnt_q >= COL_FULL) begin
                set_ovr   = 1'b1;
                per_err_d = 1'b1;
                if (col_cnt_q != COL_SAT) begin
                    col_cnt_d = col_cnt_q + (CW + 1)'(1);
                end
            end else begin
                cap_wren_d     = 1'b1;
                cap_data_d     = s_data;
                cap_col_addr_d = COL_LAST - col_cnt_q[CW-1:0];
                col_cnt_d      = col_cnt_q + (CW + 1)'(1);
            end
        end

        err_overrun_d   = err_clr ? 1'b0 : (err_overrun_q | set_ovr);
        err_clk_in_le_d = err_clr ? 1'b0 : (err_clk_in_le_q | set_cle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_SHIFT;
            col_cnt_q       <= '0;
            on_cnt_q        <= '0;
            per_err_q       <= 1'b0;
            cap_col_addr_q  <= '0;
            cap_data_q      <= '0;
            cap_wren_q      <= 1'b0;
            lat_valid_q     <= 1'b0;
            lat_row_q       <= '0;
            lat_ncols_q     <= '0;
            lat_ok_q        <= 1'b0;
            lat_on_len_q    <= '0;
            err_overrun_q   <= 1'b0;
            err_clk_in_le_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            col_cnt_q       <= col_cnt_d;
            on_cnt_q        <= on_cnt_d;
            per_err_q       <= per_err_d;
            cap_col_addr_q  <= cap_col_addr_d;
            cap_data_q      <= cap_data_d;
            cap_wren_q      <= cap_wren_d;
            lat_valid_q     <= lat_valid_d;
            lat_row_q       <= lat_row_d;
            lat_ncols_q     <= lat_ncols_d;
            lat_ok_q        <= lat_ok_d;
            lat_on_len_q    <= lat_on_len_d;
            err_overrun_q   <= err_overrun_d;
            err_clk_in_le_q <= err_clk_in_le_d;
        end
    end

    assign cap_col_addr  = cap_col_addr_q;
    assign cap_data      = cap_data_q;
    assign cap_wren      = cap_wren_q;
    assign lat_valid     = lat_valid_q;
    assign lat_row       = lat_row_q;
    assign lat_ncols     = lat_ncols_q;
    assign lat_ok        = lat_ok_q;
    assign lat_on_len    = lat_on_len_q;
    assign err_overrun   = err_overrun_q;
    assign err_clk_in_le = err_clk_in_le_q;

endmodule

// File: tb/tb_hub75_rx.sv
// Directed bench for hub75_rx: expected writes/latches are queued as the bus is
// driven and checked when the receiver emits them.
module tb_hub75_rx;
    import hub75_pkg::*;

    localparam int unsigned NB = 2;
    localparam int unsigned NR = 32;
    localparam int unsigned NC = 64;
    localparam int unsigned NCH = 3;
    localparam int unsigned CNTW = 16;
    localparam int unsigned DW = NB * NCH;

    typedef struct {
        logic [5:0]    col;
        logic [DW-1:0] data;
    } cap_t;

    typedef struct {
        logic [4:0]      row;
        logic [6:0]      ncols;
        logic            ok;
        logic [CNTW-1:0] on_len;
    } lat_t;

    logic clk = 1'b0;
    logic rst;
    logic err_clr;
    logic [5:0]      cap_col_addr;
    logic [DW-1:0]   cap_data;
    logic            cap_wren;
    logic            lat_valid;
    logic [4:0]      lat_row;
    logic [6:0]      lat_ncols;
    logic            lat_ok;
    logic [CNTW-1:0] lat_on_len;
    logic            err_overrun;
    logic            err_clk_in_le;

    int errors = 0;
    int checks = 0;

    cap_t cap_q[$];
    lat_t lat_q[$];
    int   col_model = 0;
    bit   per_err_model = 1'b0;

    always #5 clk = ~clk;

    hub75_rx_if #(.N_BANKS(NB), .N_ROWS(NR), .N_CHANS(NCH)) bus ();

    hub75_rx #(
        .N_BANKS (NB),
        .N_ROWS  (NR),
        .N_COLS  (NC),
        .N_CHANS (NCH),
        .CNT_W   (CNTW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .hub75         (bus),
        .cap_col_addr  (cap_col_addr),
        .cap_data      (cap_data),
        .cap_wren      (cap_wren),
        .lat_valid     (lat_valid),
        .lat_row       (lat_row),
        .lat_ncols     (lat_ncols),
        .lat_ok        (lat_ok),
        .lat_on_len    (lat_on_len),
        .err_overrun   (err_overrun),
        .err_clk_in_le (err_clk_in_le),
        .err_clr       (err_clr)
    );

    // Scoreboard: pop and compare whenever the receiver emits a write or latch.
    always @(negedge clk) begin
        if (cap_wren) begin
            checks++;
            assert (cap_q.size() != 0) else begin
                errors++;
                $error("FAIL cap_unexpected observed col=%0d data=%0h expected no write", cap_col_addr, cap_data);
            end
            if (cap_q.size() != 0) begin
                cap_t e;
                e = cap_q.pop_front();
                checks++;
                assert (cap_col_addr === e.col && cap_data === e.data) else begin
                    errors++;
                    $error("FAIL cap_write observed col=%0d data=%0h expected col=%0d data=%0h",
                           cap_col_addr, cap_data, e.col, e.data);
                end
            end
        end
        if (lat_valid) begin
            checks++;
            assert (lat_q.size() != 0) else begin
                errors++;
                $error("FAIL lat_unexpected observed row=%0d ncols=%0d expected no latch", lat_row, lat_ncols);
            end
            if (lat_q.size() != 0) begin
                lat_t e;
                e = lat_q.pop_front();
                checks++;
                assert (lat_row === e.row && lat_ncols === e.ncols && lat_ok === e.ok && lat_on_len === e.on_len)
                else begin
                    errors++;
                    $error("FAIL latch observed row=%0d ncols=%0d ok=%0b on=%0d expected row=%0d ncols=%0d ok=%0b on=%0d",
                           lat_row, lat_ncols, lat_ok, lat_on_len, e.row, e.ncols, e.ok, e.on_len);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic shift_col(input logic [DW-1:0] d);
        if (col_model < NC) begin
            cap_q.push_back('{col: 6'(NC - 1 - col_model), data: d});
            col_model++;
        end else begin
            per_err_model = 1'b1;
            if (col_model < NC + 1) col_model++;
        end
        bus.hub75_data = d;
        cyc(4);
        bus.hub75_clk = 1'b1;
        cyc(4);
        bus.hub75_clk = 1'b0;
        cyc(4);
    endtask

    task automatic shift_row(input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] v;
            v = i;
            shift_col(v[DW-1:0]);
        end
    endtask

    task automatic latch(input logic [4:0] addr, input logic [CNTW-1:0] on_exp, input bit toggle);
        lat_q.push_back('{row: addr, ncols: 7'(col_model),
                          ok: (col_model == NC) && !per_err_model, on_len: on_exp});
        col_model = 0;
        per_err_model = toggle;
        bus.hub75_addr = addr;
        cyc(4);
        bus.hub75_le = 1'b1;
        cyc(4);
        if (toggle) begin
            bus.hub75_clk = 1'b1;
            cyc(4);
            bus.hub75_clk = 1'b0;
            cyc(4);
        end
        bus.hub75_le = 1'b0;
        cyc(4);
    endtask

    task automatic blank_low(input int n);
        bus.hub75_blank = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        bus.hub75_blank = 1'b1;
        cyc(4);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk(tag, {cap_col_addr, cap_data, cap_wren, lat_valid, lat_row, lat_ncols, lat_ok,
                  err_overrun, err_clk_in_le}, '0);
        chk({tag, "_on"}, 32'(lat_on_len), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        err_clr = 1'b0;
        bus.hub75_addr  = '0;
        bus.hub75_data  = '0;
        bus.hub75_clk   = 1'b0;
        bus.hub75_le    = 1'b0;
        bus.hub75_blank = 1'b1;
        cyc(3);
        chk_outputs_zero("reset");
        rst = 1'b0;
        cyc(3);

        // Full row, data = column index, latch on row 5
        shift_row(64);
        latch(5'd5, '0, 1'b0);
        chk("q_empty_row", 32'(cap_q.size() + lat_q.size()), 32'd0);

        // Overrun: 66 shifts, only 64 written, count saturates at 65
        shift_row(66);
        chk("err_overrun_set", 32'(err_overrun), 32'd1);
        latch(5'd9, '0, 1'b0);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        cyc(1);
        chk("err_overrun_clr", 32'(err_overrun), 32'd0);

        // On-time: 200 blank-low cycles between two latches
        latch(5'd1, '0, 1'b0);
        blank_low(200);
        latch(5'd2, 16'd200, 1'b0);

        // Shift edge while LE high: error, no write, column count unaffected
        latch(5'd3, '0, 1'b1);
        chk("err_clk_in_le_set", 32'(err_clk_in_le), 32'd1);
        chk("err_overrun_quiet", 32'(err_overrun), 32'd0);
        shift_row(64);
        latch(5'd4, '0, 1'b0);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        cyc(1);
        chk("err_clk_in_le_clr", 32'(err_clk_in_le), 32'd0);
        shift_row(64);
        latch(5'd6, '0, 1'b0);

        // On-time counter saturation
        blank_low(70000);
        latch(5'd7, 16'hFFFF, 1'b0);

        // Reset mid-row discards the partial row
        shift_row(30);
        chk("q_empty_pre_rst", 32'(cap_q.size() + lat_q.size()), 32'd0);
        rst = 1'b1;
        #2;
        chk_outputs_zero("mid_reset");
        cyc(3);
        chk_outputs_zero("mid_reset_hold");
        col_model = 0;
        per_err_model = 1'b0;
        rst = 1'b0;
        cyc(3);
        shift_row(64);
        latch(5'd31, '0, 1'b0);

        cyc(10);
        chk("q_empty_end", 32'(cap_q.size() + lat_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
